// File: rtl/pifo_pkg.sv
// Shared types and constants for the PIFO flow scheduler.
// Holds widths, per-flow config struct, FSM states and the decay helper.
package pifo_pkg;

    localparam int NUM_FLOWS    = 16;
    localparam int MAX_PRIORITY = 256;
    localparam int MAX_PKTS     = 63;
    localparam int PRIO_WIDTH   = $clog2(MAX_PRIORITY);
    localparam int FLOW_WIDTH   = $clog2(NUM_FLOWS);
    localparam int CNT_WIDTH    = $clog2(MAX_PKTS + 1);

    typedef logic [PRIO_WIDTH-1:0] prio_t;
    typedef logic [FLOW_WIDTH-1:0] flow_t;
    typedef logic [CNT_WIDTH-1:0]  cnt_t;

    typedef struct packed {
        prio_t base_prio;
        prio_t step;
    } sched_flow_cfg_t;

    typedef enum logic {
        RUN,
        FLUSH
    } sched_state_e;

    // Priority after one service; a live flow never drops below 1.
    function automatic prio_t decay(prio_t p, prio_t s);
        return (p > s) ? prio_t'(p - s) : prio_t'(1);
    endfunction

endpackage

// File: rtl/pifo_flow_scheduler_if.sv
// Link between the scheduler and a pifo_set instance.
// master = scheduler side (drives push/pop/reinsert/clear), slave = pifo_set side.
interface pifo_flow_scheduler_if;
    import pifo_pkg::*;

    logic  push_valid;
    prio_t push_priority;
    flow_t push_flow_id;
    logic  set_ready;
    logic  pop_valid;
    prio_t pop_priority;
    flow_t pop_flow_id;
    logic  pop;
    logic  reinsert_valid;
    prio_t reinsert_priority;
    logic  clear_all;

    modport master (
        output push_valid, push_priority, push_flow_id,
        output pop, reinsert_valid, reinsert_priority, clear_all,
        input  set_ready, pop_valid, pop_priority, pop_flow_id
    );

    modport slave (
        input  push_valid, push_priority, push_flow_id,
        input  pop, reinsert_valid, reinsert_priority, clear_all,
        output set_ready, pop_valid, pop_priority, pop_flow_id
    );

endinterface

// File: rtl/pifo_flow_counter_bank.sv
// Per-flow packet counters with one increment and one decrement port.
// Ports: clear, inc/inc_id, dec/dec_id, zero/full flags for rd_a, count for rd_b.
module pifo_flow_counter_bank #(
    parameter int N   = 16,
    parameter int W   = 6,
    parameter int MAX = 63
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i__clear,
    input  logic                 i__inc,
    input  logic [$clog2(N)-1:0] i__inc_id,
    input  logic                 i__dec,
    input  logic [$clog2(N)-1:0] i__dec_id,
    input  logic [$clog2(N)-1:0] i__rd_a_id,
    output logic                 o__a_zero,
    output logic                 o__a_full,
    input  logic [$clog2(N)-1:0] i__rd_b_id,
    output logic [W-1:0]         o__b_cnt
);
    localparam int IDW = $clog2(N);

    logic [W-1:0] cnt_q [N];
    logic [W-1:0] cnt_d [N];

    always_comb begin
        cnt_d = cnt_q;
        for (int f = 0; f < N; f++) begin
            if (i__clear) begin
                cnt_d[f] = '0;
            end else begin
                // inc and dec on the same flow cancel out
                if (i__inc && i__inc_id == IDW'(f))
                    cnt_d[f] = cnt_d[f] + W'(1);
                if (i__dec && i__dec_id == IDW'(f))
                    cnt_d[f] = cnt_d[f] - W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int f = 0; f < N; f++)
                cnt_q[f] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o__a_zero = cnt_q[i__rd_a_id] == '0;
    assign o__a_full = cnt_q[i__rd_a_id] == W'(MAX);
    assign o__b_cnt  = cnt_q[i__rd_b_id];

endmodule

// File: rtl/pifo_flow_scheduler.sv
// Per-flow scheduler driving a pifo_set: push on empty->busy, pop+reinsert on dequeue.
// Ports: arrival handshake, dequeue request/result, per-flow config, flush, pifo_set controls.
module pifo_flow_scheduler
    import pifo_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  i__arr_valid,
    input  flow_t i__arr_flow_id,
    output logic  o__arr_ready,
    input  logic  i__deq_req,
    output logic  o__deq_valid,
    output flow_t o__deq_flow_id,
    input  logic  i__cfg_valid,
    input  flow_t i__cfg_flow_id,
    input  prio_t i__cfg_base_prio,
    input  prio_t i__cfg_step,
    input  logic  i__flush,
    output logic  o__busy,
    output logic  o__pifo_push_valid,
    output prio_t o__pifo_push_priority,
    output flow_t o__pifo_push_flow_id,
    input  logic  i__pifo_set_ready,
    input  logic  i__pifo_pop_valid,
    input  prio_t i__pifo_pop_priority,
    input  flow_t i__pifo_pop_flow_id,
    output logic  o__pifo_pop,
    output logic  o__pifo_reinsert_valid,
    output prio_t o__pifo_reinsert_priority,
    output logic  o__pifo_clear_all
);

    sched_state_e    state_q, state_d;
    sched_flow_cfg_t cfg_q [NUM_FLOWS];
    sched_flow_cfg_t cfg_d [NUM_FLOWS];
    logic            deq_valid_q, deq_valid_d;
    flow_t           deq_flow_q, deq_flow_d;

    logic a_zero, a_full;
    cnt_t p_cnt;
    logic run, pop, same, acc;

    pifo_flow_counter_bank #(
        .N   (NUM_FLOWS),
        .W   (CNT_WIDTH),
        .MAX (MAX_PKTS)
    ) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .i__clear   (state_q == FLUSH),
        .i__inc     (acc),
        .i__inc_id  (i__arr_flow_id),
        .i__dec     (pop),
        .i__dec_id  (i__pifo_pop_flow_id),
        .i__rd_a_id (i__arr_flow_id),
        .o__a_zero  (a_zero),
        .o__a_full  (a_full),
        .i__rd_b_id (i__pifo_pop_flow_id),
        .o__b_cnt   (p_cnt)
    );

    always_comb begin
        run  = state_q == RUN;
        pop  = run & i__deq_req & i__pifo_pop_valid;
        same = pop & (i__arr_flow_id == i__pifo_pop_flow_id);

        // an empty flow needs a pifo slot unless it rides on the reinsert
        o__arr_ready = run & ~a_full
                     & ~(a_zero & ~same & ~i__pifo_set_ready);
        acc = i__arr_valid & o__arr_ready;

        o__pifo_pop           = pop;
        o__pifo_push_valid    = acc & a_zero & ~same;
        o__pifo_push_priority = o__pifo_push_valid ?
                                cfg_q[i__arr_flow_id].base_prio : '0;
        o__pifo_push_flow_id  = o__pifo_push_valid ?
                                i__arr_flow_id : '0;

        o__pifo_reinsert_valid    = pop & ((p_cnt > cnt_t'(1)) | (acc & same));
        o__pifo_reinsert_priority = o__pifo_reinsert_valid ?
            decay(i__pifo_pop_priority, cfg_q[i__pifo_pop_flow_id].step) : '0;

        o__pifo_clear_all = state_q == FLUSH;
        o__busy           = state_q == FLUSH;

        state_d     = i__flush ? FLUSH : RUN;
        deq_valid_d = pop;
        deq_flow_d  = pop ? i__pifo_pop_flow_id : deq_flow_q;

        cfg_d = cfg_q;
        if (i__cfg_valid)
            cfg_d[i__cfg_flow_id] = '{base_prio: i__cfg_base_prio,
                                      step:      i__cfg_step};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            deq_valid_q <= 1'b0;
            deq_flow_q  <= '0;
            for (int f = 0; f < NUM_FLOWS; f++)
                cfg_q[f] <= '{base_prio: prio_t'(MAX_PRIORITY - 1),
                              step:      prio_t'(1)};
        end else begin
            state_q     <= state_d;
            deq_valid_q <= deq_valid_d;
            deq_flow_q  <= deq_flow_d;
            cfg_q       <= cfg_d;
        end
    end

    assign o__deq_valid   = deq_valid_q;
    assign o__deq_flow_id = deq_flow_q;

endmodule

// File: tb/tb_pifo_flow_scheduler.sv
// Bench for pifo_flow_scheduler with a behavioural pifo_set on the link.
// Reference counts/config predict every control output; dequeues go through a scoreboard.
module tb_pifo_flow_scheduler;
    import pifo_pkg::*;

    logic  clk = 1'b0;
    logic  reset;
    logic  arr_valid, arr_ready;
    flow_t arr_id;
    logic  deq_req, deq_valid;
    flow_t deq_flow;
    logic  cfg_valid;
    flow_t cfg_id;
    prio_t cfg_base, cfg_step;
    logic  flush, busy;

    always #5 clk = ~clk;

    pifo_flow_scheduler_if pif ();

    pifo_flow_scheduler dut (
        .clk                       (clk),
        .reset                     (reset),
        .i__arr_valid              (arr_valid),
        .i__arr_flow_id            (arr_id),
        .o__arr_ready              (arr_ready),
        .i__deq_req                (deq_req),
        .o__deq_valid              (deq_valid),
        .o__deq_flow_id            (deq_flow),
        .i__cfg_valid              (cfg_valid),
        .i__cfg_flow_id            (cfg_id),
        .i__cfg_base_prio          (cfg_base),
        .i__cfg_step               (cfg_step),
        .i__flush                  (flush),
        .o__busy                   (busy),
        .o__pifo_push_valid        (pif.push_valid),
        .o__pifo_push_priority     (pif.push_priority),
        .o__pifo_push_flow_id      (pif.push_flow_id),
        .i__pifo_set_ready         (pif.set_ready),
        .i__pifo_pop_valid         (pif.pop_valid),
        .i__pifo_pop_priority      (pif.pop_priority),
        .i__pifo_pop_flow_id       (pif.pop_flow_id),
        .o__pifo_pop               (pif.pop),
        .o__pifo_reinsert_valid    (pif.reinsert_valid),
        .o__pifo_reinsert_priority (pif.reinsert_priority),
        .o__pifo_clear_all         (pif.clear_all)
    );

    // behavioural pifo_set: head is the highest priority, lowest id on ties
    logic  env_present [NUM_FLOWS];
    prio_t env_prio    [NUM_FLOWS];
    logic  env_ready;

    always_comb begin : head
        logic  hv;
        prio_t hp;
        flow_t hf;
        hv = 1'b0;
        hp = '0;
        hf = '0;
        for (int f = 0; f < NUM_FLOWS; f++) begin
            if (env_present[f] && (!hv || env_prio[f] > hp)) begin
                hv = 1'b1;
                hp = env_prio[f];
                hf = flow_t'(f);
            end
        end
        pif.set_ready    = env_ready;
        pif.pop_valid    = hv;
        pif.pop_priority = hp;
        pif.pop_flow_id  = hf;
    end

    int ref_cnt  [NUM_FLOWS];
    int ref_base [NUM_FLOWS];
    int ref_step [NUM_FLOWS];
    bit ref_fl;

    typedef struct packed {
        logic  v;
        flow_t f;
    } deq_t;
    deq_t sb [$];

    int n_chk = 0;
    int n_pass = 0;

    logic last_ready, last_push, last_pop, last_rv, last_clear, last_busy;
    int   last_pp, last_pf, last_rp;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic idle();
        arr_valid = 0; arr_id = '0; deq_req = 0;
        cfg_valid = 0; cfg_id = '0; cfg_base = '0; cfg_step = '0;
        flush = 0;
    endtask

    task automatic model_reset();
        for (int f = 0; f < NUM_FLOWS; f++) begin
            ref_cnt[f] = 0; ref_base[f] = 255; ref_step[f] = 1;
            env_present[f] = 0; env_prio[f] = '0;
        end
        ref_fl = 0;
        sb.delete();
    endtask

    task automatic cycle();
        int a, p, remain, d, erp;
        bit run, epop, erdy, acc, epush, erv;
        deq_t e;
        #3;
        run  = !ref_fl;
        a    = int'(arr_id);
        p    = int'(pif.pop_flow_id);
        epop = run && deq_req && pif.pop_valid;
        erdy = run && ref_cnt[a] != MAX_PKTS && !(ref_cnt[a] == 0 && !env_ready);
        acc  = arr_valid && erdy;
        epush  = acc && ref_cnt[a] == 0 && !(epop && a == p);
        remain = ref_cnt[p] - 1 + ((acc && a == p) ? 1 : 0);
        erv = epop && remain > 0;
        d   = int'(pif.pop_priority) - ref_step[p];
        erp = erv ? ((d < 1) ? 1 : d) : 0;

        last_ready = arr_ready;  last_push = pif.push_valid;
        last_pp    = int'(pif.push_priority);
        last_pf    = int'(pif.push_flow_id);
        last_pop   = pif.pop;    last_rv = pif.reinsert_valid;
        last_rp    = int'(pif.reinsert_priority);
        last_clear = pif.clear_all; last_busy = busy;

        chk("arr_ready", arr_ready, erdy);
        chk("push_valid", pif.push_valid, epush);
        if (epush) begin
            chk("push_prio", pif.push_priority, ref_base[a]);
            chk("push_flow", pif.push_flow_id, a);
        end
        chk("pop", pif.pop, epop);
        chk("reins_valid", pif.reinsert_valid, erv);
        chk("reins_prio", pif.reinsert_priority, erp);
        chk("clear_all", pif.clear_all, ref_fl);
        chk("busy", busy, ref_fl);
        sb.push_back('{v: epop, f: flow_t'(p)});

        if (ref_fl) begin
            for (int f = 0; f < NUM_FLOWS; f++) ref_cnt[f] = 0;
        end else begin
            if (acc)  ref_cnt[a]++;
            if (epop) ref_cnt[p]--;
        end
        if (cfg_valid) begin
            ref_base[cfg_id] = int'(cfg_base);
            ref_step[cfg_id] = int'(cfg_step);
        end
        ref_fl = flush;

        @(posedge clk);
        #1;
        if (last_clear) begin
            for (int f = 0; f < NUM_FLOWS; f++) env_present[f] = 0;
        end else begin
            if (last_pop) env_present[p] = 0;
            if (last_rv) begin
                env_present[p] = 1; env_prio[p] = prio_t'(last_rp);
            end
            if (last_push) begin
                env_present[last_pf] = 1; env_prio[last_pf] = prio_t'(last_pp);
            end
        end
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("deq_valid", deq_valid, e.v);
            if (e.v) chk("deq_flow", deq_flow, e.f);
        end
    endtask

    task automatic op(bit av, int aid, bit dq);
        idle();
        arr_valid = av; arr_id = flow_t'(aid); deq_req = dq;
        cycle();
    endtask

    task automatic cfg(int f, int b, int s);
        idle();
        cfg_valid = 1; cfg_id = flow_t'(f);
        cfg_base = prio_t'(b); cfg_step = prio_t'(s);
        cycle();
    endtask

    task automatic do_reset();
        reset = 1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        reset = 0;
        #1;
        chk("rst_deq_valid", deq_valid, 0);
        chk("rst_deq_flow", deq_flow, 0);
        chk("rst_busy", busy, 0);
        chk("rst_clear", pif.clear_all, 0);
        chk("rst_push", pif.push_valid, 0);
        chk("rst_pop", pif.pop, 0);
        chk("rst_reins", pif.reinsert_valid, 0);
    endtask

    initial begin
        env_ready = 1;
        do_reset();

        op(1, 3, 0);
        chk("t1_push", last_push, 1);
        chk("t1_prio", last_pp, 255);
        chk("t1_flow", last_pf, 3);
        op(0, 0, 1);
        chk("t1_pop", last_pop, 1);
        chk("t1_rv", last_rv, 0);
        chk("t1_deq_valid", deq_valid, 1);
        chk("t1_deq_flow", deq_flow, 3);

        cfg(5, 100, 30);
        repeat (3) op(1, 5, 0);
        op(0, 0, 1);
        chk("t2_rp70", last_rp, 70);
        op(0, 0, 1);
        chk("t2_rp40", last_rp, 40);
        op(0, 0, 1);
        chk("t2_pop3", last_pop, 1);
        chk("t2_rv3", last_rv, 0);
        op(0, 0, 1);
        chk("t2_empty", deq_valid, 0);

        cfg(2, 100, 200);
        op(1, 2, 0);
        op(1, 2, 0);
        op(0, 0, 1);
        chk("t3_rv", last_rv, 1);
        chk("t3_floor", last_rp, 1);
        op(0, 0, 1);

        op(1, 7, 0);
        op(1, 7, 1);
        chk("t4_push", last_push, 0);
        chk("t4_rv", last_rv, 1);
        chk("t4_pop", last_pop, 1);
        op(0, 0, 1);
        chk("t4_last_pop", last_pop, 1);
        chk("t4_last_rv", last_rv, 0);
        op(0, 0, 1);
        chk("t4_empty", deq_valid, 0);

        repeat (63) op(1, 1, 0);
        op(1, 1, 0);
        chk("t5_full", last_ready, 0);
        op(1, 2, 0);
        chk("t5_other", last_ready, 1);
        chk("t5_push2", last_pp, 100);

        env_ready = 0;
        op(1, 9, 0);
        chk("t6_noslot", last_ready, 0);
        op(1, 2, 0);
        chk("t6_live", last_ready, 1);
        env_ready = 1;

        op(1, 4, 0);
        op(1, 6, 0);
        idle(); flush = 1; cycle();
        idle();
        arr_valid = 1; arr_id = 4; deq_req = 1;
        cfg_valid = 1; cfg_id = 4; cfg_base = 50; cfg_step = 5;
        cycle();
        chk("t7_clear", last_clear, 1);
        chk("t7_busy", last_busy, 1);
        chk("t7_ready", last_ready, 0);
        chk("t7_pop", last_pop, 0);
        op(0, 0, 0);
        chk("t7_busy_off", last_busy, 0);
        op(0, 0, 1);
        chk("t7_deq_empty", deq_valid, 0);
        op(1, 4, 0);
        chk("t7_repush", last_push, 1);
        chk("t7_cfg_prio", last_pp, 50);

        idle(); flush = 1; cycle();
        idle(); flush = 1; cycle();
        chk("t8_first", last_busy, 1);
        op(0, 0, 0);
        chk("t8_reenter", last_busy, 1);
        op(0, 0, 0);
        chk("t8_done", last_busy, 0);

        for (int i = 0; i < 400; i++) begin
            idle();
            arr_valid = 1'($urandom_range(0, 1));
            arr_id    = flow_t'($urandom_range(0, 5));
            deq_req   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) begin
                cfg_valid = 1;
                cfg_id    = flow_t'($urandom_range(0, 5));
                cfg_base  = prio_t'($urandom_range(1, 255));
                cfg_step  = prio_t'($urandom_range(0, 255));
            end
            flush     = ($urandom_range(0, 59) == 0);
            env_ready = ($urandom_range(0, 7) != 0);
            cycle();
        end
        env_ready = 1;

        op(1, 5, 0);
        do_reset();
        op(1, 5, 0);
        chk("t9_push", last_push, 1);
        chk("t9_prio", last_pp, 255);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pifo_flow_scheduler.md
Name: pifo_flow_scheduler

Overview:
- Controller that sequences one pifo_set instance as a per-flow packet scheduler.
- Keeps a packet count per flow and pushes a flow into the PIFO when it goes from empty to non-empty.
- On each egress dequeue request, pops the head flow and reinserts it in the same cycle with a decayed priority if it still holds packets.
- Sits between ingress (arrival notifications) and egress (dequeue requests); owns the pifo_set push, pop, reinsert and clear controls.

Parameters:
- NUM_FLOWS, 16, number of flows; must equal pifo_set NUM_ELEMENTS.
- MAX_PRIORITY, 256, priority range; PRIO_WIDTH = clog2(MAX_PRIORITY).
- MAX_PKTS, 63, per-flow packet count ceiling; CNT_WIDTH = clog2(MAX_PKTS+1).
- FLOW_WIDTH, clog2(NUM_FLOWS), flow-id width; equals pifo_set DATA_WIDTH.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i__arr_valid  in  1  packet arrival for a flow
- i__arr_flow_id  in  FLOW_WIDTH  arriving flow
- o__arr_ready  out  1  arrival accepted when valid&ready
- i__deq_req  in  1  egress requests one scheduling decision
- o__deq_valid  out  1  registered: decision valid
- o__deq_flow_id  out  FLOW_WIDTH  registered: scheduled flow
- i__cfg_valid  in  1  write per-flow config
- i__cfg_flow_id  in  FLOW_WIDTH  config target
- i__cfg_base_prio  in  PRIO_WIDTH  push priority for the flow
- i__cfg_step  in  PRIO_WIDTH  priority decrement per service
- i__flush  in  1  drop all state
- o__busy  out  1  high while in FLUSH
- o__pifo_push_valid  out  1  to pifo_set i__push_valid
- o__pifo_push_priority  out  PRIO_WIDTH  to pifo_set
- o__pifo_push_flow_id  out  FLOW_WIDTH  to pifo_set
- i__pifo_set_ready  in  1  from pifo_set
- i__pifo_pop_valid  in  1  from pifo_set
- i__pifo_pop_priority  in  PRIO_WIDTH  from pifo_set
- i__pifo_pop_flow_id  in  FLOW_WIDTH  from pifo_set
- o__pifo_pop  out  1  to pifo_set i__pop
- o__pifo_reinsert_valid  out  1  to pifo_set
- o__pifo_reinsert_priority  out  PRIO_WIDTH  to pifo_set; 0 means no reinsert
- o__pifo_clear_all  out  1  to pifo_set

Behaviour:
- Single clock (clk); reset is synchronous and active-high.
- Reset state:
  - FSM in RUN; all counts 0.
  - base_prio[f] = MAX_PRIORITY-1; step[f] = 1.
  - o__deq_valid = 0, o__deq_flow_id = 0, o__busy = 0, all pifo controls 0.
- FSM states RUN and FLUSH.
  - RUN -> FLUSH on i__flush.
  - FLUSH lasts exactly one cycle, then returns to RUN.
- FLUSH cycle:
  - o__pifo_clear_all = 1, o__busy = 1.
  - Counts zeroed at the next edge.
  - o__arr_ready = 0; pop, push and reinsert held at 0.
  - Config writes are still honoured.
  - i__flush asserted again while in FLUSH re-enters FLUSH.
- Pop (combinational, RUN only): o__pifo_pop = i__deq_req & i__pifo_pop_valid. Call this `pop`; the popped flow is P = i__pifo_pop_flow_id.
- Reinsert (same cycle as pop):
  - Let remain = count[P] - 1, plus 1 if an arrival for P is accepted this cycle.
  - If remain > 0: o__pifo_reinsert_priority = max(1, pop_priority - step[P]).
  - Otherwise 0.
  - o__pifo_reinsert_valid follows the same condition.
  - Priority 0 is never produced for a live flow; saturation floor is 1.
- Arrival for flow A (RUN):
  - o__arr_ready = 0 if count[A] == MAX_PKTS.
  - o__arr_ready = 0 if count[A] == 0, A is not P-being-reinserted, and i__pifo_set_ready = 0.
  - Otherwise o__arr_ready = 1.
- Push:
  - o__pifo_push_valid = accepted arrival & count[A] == 0 & !(pop & A == P).
  - Priority = base_prio[A].
  - Arrival to the flow being popped never pushes; it folds into the reinsert.
- Counts at the next edge:
  - count[A] += 1 on an accepted arrival.
  - count[P] -= 1 on pop.
  - Both on the same flow: net 0.
- Dequeue output: o__deq_valid and o__deq_flow_id register pop and P, giving 1-cycle latency. i__deq_req while the PIFO is empty yields o__deq_valid = 0 the next cycle.
- Config: takes effect at the next edge. A pop in the same cycle as a step write uses the old step.
- Invariant: each flow is present in the PIFO at most once, and count[f] > 0 iff f is in the PIFO.
- Reset mid-operation: all state returns to reset values. Reset does not drive o__pifo_clear_all; pifo_set receives the same reset.

Decomposition:
- Shared package pifo_pkg holds:
  - PRIO_WIDTH and FLOW_WIDTH derivation.
  - SchedFlowCfg struct {base_prio, step}.
  - Sched state enum {RUN, FLUSH}.
- One natural sub-module, pifo_flow_counter_bank: per-flow count array with inc/dec ports, zero/full flags, and clear.

Test Plan:
- After reset:
  - Arrive flow 3 -> push_valid=1, prio 255, flow 3.
  - deq_req next cycle -> pop=1, reinsert_valid=0.
  - Following cycle o__deq_valid=1, o__deq_flow_id=3.
- Flow 5 cfg base=100, step=30, 3 arrivals; three deq_reqs:
  - Reinsert priorities 70, then 40.
  - Third pop has no reinsert; count[5] ends at 0.
- Step=200 on flow 2 at priority 100 with 2 packets -> reinsert prio 1 (floor), not 0.
- Flow 7 holds 1 packet; arrival for 7 and pop of 7 in the same cycle -> push_valid=0, reinsert_valid=1, count[7] stays 1.
- Fill flow 1 to MAX_PKTS=63 -> arr_ready=0 for flow 1; arr_ready=1 for flow 2.
- i__flush with 4 flows active -> clear_all=1 and busy=1 for one cycle, arr_ready=0 that cycle; afterwards deq_req gives o__deq_valid=0 and a fresh arrival pushes again.
